pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 8-bit, five-stage core with eight registers and 3-bit register numbers. It watches the ID, EXE and MEM stages and drives the hold/flush controls of the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers and the PC. It resolves three cases: load-use hazards, taken branches resolved in EXE, and multi-cycle data-memory accesses through a req/ready handshake with a timeout. It also keeps a saturating stall-cycle performance counter.

## Interface
- TIMEOUT, 15: maximum wait cycles per memory access before forced release (1..255).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  3 each  source register numbers of the instruction in ID.
- id_use1, id_use2  in  1 each  the instruction in ID actually reads rs1 / rs2.
- exe_memRd  in  1  the instruction in EXE is a load.
- exe_rd  in  3  destination register of the instruction in EXE.
- br_taken  in  1  the branch in EXE is taken this cycle.
- mem_memRd, mem_memWr  in  1 each  the instruction in MEM reads / writes data memory.
- mem_ready  in  1  data memory completes the current access this cycle.
- pc_en  out  1  PC loads its next value.
- ifid_en  out  1  IF/ID register loads.
- idexe_en  out  1  ID/EXE register loads.
- exemem_en  out  1  EXE/MEM register loads.
- ifid_flush, idexe_flush, memwb_flush  out  1 each  load a bubble (all control bits 0) into that register.
- mem_req  out  1  data-memory access request.
- mem_timeout  out  1  sticky flag: some access hit TIMEOUT.
- stall_cnt  out  8  saturating count of cycles with pc_en=0.

## Operation
- Registered state: fsm ∈ {RUN, MEM_WAIT}, wait_cnt (8 bit), mem_timeout, stall_cnt. All control outputs are combinational from state and the current inputs.
- Derived terms:
  - acc = mem_memRd | mem_memWr.
  - lu = exe_memRd & ((id_use1 & id_rs1==exe_rd) | (id_use2 & id_rs2==exe_rd)). Register 0 is not special-cased.
  - rel = mem_ready | (fsm==MEM_WAIT & wait_cnt==TIMEOUT).
- mem_req = acc while not rst. It stays high every cycle until rel.
- Priority 1, memory freeze (acc & !rel):
  - pc_en = ifid_en = idexe_en = exemem_en = 0.
  - memwb_flush = 1.
  - ifid_flush = idexe_flush = 0.
  - br_taken and lu are ignored this cycle. The frozen stages hold their inputs, so both are re-evaluated next cycle.
- Priority 2, branch (br_taken, no freeze):
  - all enables = 1; ifid_flush = idexe_flush = 1; memwb_flush = 0.
  - Any coincident lu is discarded, because the ID instruction is squashed.
- Priority 3, load-use (lu, no freeze, no branch):
  - pc_en = ifid_en = 0; idexe_en = exemem_en = 1; idexe_flush = 1.
  - The bubble enters EXE, so lu drops next cycle: exactly one stall cycle per load-use.
- Otherwise: all enables 1, all flushes 0.
- FSM:
  - RUN → MEM_WAIT when acc & !mem_ready.
  - MEM_WAIT → RUN when rel.
  - RUN stays in RUN when acc & mem_ready (zero-wait access: no stall).
- wait_cnt:
  - cleared in RUN;
  - increments each MEM_WAIT cycle without rel;
  - cleared on leaving MEM_WAIT.
- Timeout: when MEM_WAIT and wait_cnt==TIMEOUT and !mem_ready:
  - set mem_timeout (held until rst);
  - release the pipeline as if ready; load data is undefined.
- stall_cnt increments on every non-reset cycle with pc_en=0 and saturates at 255.

## Timing
- While rst=1:
  - fsm=RUN; wait_cnt=0; stall_cnt=0; mem_timeout=0.
  - Outputs: all enables 1, all flushes 1, mem_req=0.
  - The first cycle after rst deasserts evaluates normally.
- rst during MEM_WAIT aborts the access: mem_req drops in that same cycle and the FSM is in RUN after the edge.
- Memory access that completes k cycles after mem_req rises (k=0 means ready in the first cycle): k freeze cycles, and the advance occurs at the edge where mem_ready=1.
- Timed-out access:
  - TIMEOUT+1 freeze cycles; the pipeline advances at the edge ending the cycle where wait_cnt==TIMEOUT;
  - mem_timeout is visible on the next cycle.
- Back-to-back accesses in consecutive MEM instructions are each handshaken independently. No idle cycle is required between them.
- Branch and load-use controls take effect at the clock edge that ends the cycle in which they are detected.

## Test plan
- Load-use: load r3 in EXE, ID reads r3 as rs2 with id_use2=1 → one cycle with pc_en=0, ifid_en=0, idexe_flush=1; stall_cnt=1; the next cycle has no stall.
- Same registers but id_use2=0, or exe_memRd=0 → no stall; stall_cnt stays 0.
- Branch with coincident lu → ifid_flush=idexe_flush=1, pc_en=1, no stall; stall_cnt unchanged.
- Load in MEM, mem_ready rises on the 4th request cycle, with br_taken held high throughout → 3 freeze cycles with memwb_flush=1; the branch flush fires in the advance cycle; stall_cnt=3.
- TIMEOUT=2, mem_ready never rises → 3 freeze cycles, then release; mem_timeout=1 and stays 1 through further traffic until rst.
- rst asserted in the 2nd MEM_WAIT cycle → mem_req=0 that cycle; after deassert: fsm=RUN, stall_cnt=0, mem_timeout=0, and the next access with mem_ready=1 causes no stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 8-bit five-stage core: load-use stalls,
// EXE-resolved branch flushes, and data-memory freeze with timeout.
module pipe_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [2:0] i_id_rs1,
   input  logic [2:0] i_id_rs2,
   input  logic       i_id_use1,
   input  logic       i_id_use2,
   input  logic       i_exe_memRd,
   input  logic [2:0] i_exe_rd,
   input  logic       i_br_taken,
   input  logic       i_mem_memRd,
   input  logic       i_mem_memWr,
   input  logic       i_mem_ready,
   output logic       o_pc_en,
   output logic       o_ifid_en,
   output logic       o_idexe_en,
   output logic       o_exemem_en,
   output logic       o_ifid_flush,
   output logic       o_idexe_flush,
   output logic       o_memwb_flush,
   output logic       o_mem_req,
   output logic       o_mem_timeout,
   output logic [7:0] o_stall_cnt
);

   typedef enum logic [0:0] {StRun, StMemWait} state_e;

   localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

   state_e     r_state;
   state_e     w_state_d;
   logic [7:0] r_wait_cnt;
   logic [7:0] w_wait_cnt_d;
   logic       r_mem_timeout;
   logic       w_mem_timeout_d;
   logic [7:0] r_stall_cnt;
   logic [7:0] w_stall_cnt_d;

   logic w_acc;
   logic w_lu;
   logic w_at_limit;
   logic w_rel;
   logic w_freeze;

   always_comb begin
      w_acc      = i_mem_memRd | i_mem_memWr;
      w_lu       = i_exe_memRd & ((i_id_use1 & (i_id_rs1 == i_exe_rd)) |
                                  (i_id_use2 & (i_id_rs2 == i_exe_rd)));
      w_at_limit = (r_state == StMemWait) && (r_wait_cnt == TimeoutVal);
      w_rel      = i_mem_ready | w_at_limit;
      w_freeze   = w_acc & ~w_rel;
   end

   // Pipeline controls; freeze outranks branch, branch outranks load-use.
   always_comb begin
      o_pc_en       = 1'b1;
      o_ifid_en     = 1'b1;
      o_idexe_en    = 1'b1;
      o_exemem_en   = 1'b1;
      o_ifid_flush  = 1'b0;
      o_idexe_flush = 1'b0;
      o_memwb_flush = 1'b0;
      o_mem_req     = w_acc;
      if (i_rst) begin
         o_ifid_flush  = 1'b1;
         o_idexe_flush = 1'b1;
         o_memwb_flush = 1'b1;
         o_mem_req     = 1'b0;
      end else if (w_freeze) begin
         o_pc_en       = 1'b0;
         o_ifid_en     = 1'b0;
         o_idexe_en    = 1'b0;
         o_exemem_en   = 1'b0;
         o_memwb_flush = 1'b1;
      end else if (i_br_taken) begin
         o_ifid_flush  = 1'b1;
         o_idexe_flush = 1'b1;
      end else if (w_lu) begin
         o_pc_en       = 1'b0;
         o_ifid_en     = 1'b0;
         o_idexe_flush = 1'b1;
      end
   end

   always_comb begin
      w_state_d       = r_state;
      w_wait_cnt_d    = r_wait_cnt;
      w_mem_timeout_d = r_mem_timeout;
      unique case (r_state)
         StRun: begin
            w_wait_cnt_d = 8'd0;
            if (w_acc && !i_mem_ready) begin
               w_state_d = StMemWait;
            end
         end
         StMemWait: begin
            if (w_rel) begin
               w_state_d    = StRun;
               w_wait_cnt_d = 8'd0;
            end else begin
               w_wait_cnt_d = r_wait_cnt + 8'd1;
            end
            if (w_at_limit && !i_mem_ready) begin
               w_mem_timeout_d = 1'b1;
            end
         end
         default: begin
            w_state_d    = StRun;
            w_wait_cnt_d = 8'd0;
         end
      endcase
   end

   always_comb begin
      w_stall_cnt_d = r_stall_cnt;
      if (!o_pc_en && (r_stall_cnt != 8'hFF)) begin
         w_stall_cnt_d = r_stall_cnt + 8'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= StRun;
         r_wait_cnt    <= 8'd0;
         r_mem_timeout <= 1'b0;
         r_stall_cnt   <= 8'd0;
      end else begin
         r_state       <= w_state_d;
         r_wait_cnt    <= w_wait_cnt_d;
         r_mem_timeout <= w_mem_timeout_d;
         r_stall_cnt   <= w_stall_cnt_d;
      end
   end

   assign o_mem_timeout = r_mem_timeout;
   assign o_stall_cnt   = r_stall_cnt;

endmodule
